// File: rtl/fproc_arbiter_if.sv
// fproc_arbiter_if: single-outstanding req/ack request channel plus result strobe
// between the fproc arbiter (master) and the shared function processor (slave).
interface fproc_arbiter_if #(
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  fp_req;
    logic [ID_WIDTH-1:0]   fp_id;
    logic                  fp_ack;
    logic                  fp_valid;
    logic [DATA_WIDTH-1:0] fp_data;

    modport master (
        output fp_req,
        output fp_id,
        input  fp_ack,
        input  fp_valid,
        input  fp_data
    );

    modport slave (
        input  fp_req,
        input  fp_id,
        output fp_ack,
        output fp_valid,
        output fp_data
    );
endinterface

// File: rtl/fproc_arbiter.sv
// fproc_arbiter: queues one fproc request per core, grants round-robin, runs one fproc transaction
// at a time and returns the result as a one-cycle strobe. Optional watchdog: FPROC_ARB_TIMEOUT_EN.
module fproc_arbiter #(
    parameter int N_CORES     = 4,
    parameter int ID_WIDTH    = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CORES-1:0]          core_en,
    input  logic [N_CORES*ID_WIDTH-1:0] core_id,
    output logic [N_CORES-1:0]          core_valid,
    output logic [DATA_WIDTH-1:0]       core_data,
    output logic                        core_err,
    fproc_arbiter_if.master             fp,
    output logic                        busy
);

    localparam int PTR_W = $clog2(N_CORES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RETURN
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   gnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [N_CORES-1:0] pending;
    logic [ID_WIDTH-1:0] id_reg [N_CORES];
    logic               err_q;
    logic               timed_out;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   grant_next_ptr;
    logic [N_CORES-1:0] grant_clr;
    logic [PTR_W:0]     scan;
    logic [N_CORES-1:0] gnt_mask;

    // Round-robin pick: first pending core at or after rr_ptr, wrapping past the top index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int i = 0; i < N_CORES; i++) begin
            scan = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (scan >= (PTR_W+1)'(N_CORES)) begin
                scan = scan - (PTR_W+1)'(N_CORES);
            end
            if (!grant_found && pending[scan[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[PTR_W-1:0];
            end
        end
    end

    assign grant_next_ptr = (grant_idx == PTR_W'(N_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign grant_clr      = (state == IDLE && grant_found) ? (N_CORES'(1) << grant_idx) : '0;
    assign gnt_mask       = N_CORES'(1) << gnt;
    assign busy           = (state != IDLE) || (|pending);
    assign core_err       = err_q;

    // Request capture: a core with a request already queued cannot replace its id.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            // NOTE: the id registers are a small flop array, so they are cleared with everything else;
            // a RAM-backed store would be left out of the reset instead.
            for (int k = 0; k < N_CORES; k++) begin
                id_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CORES; k++) begin
                if (core_en[k] && !pending[k]) begin
                    pending[k] <= 1'b1;
                    id_reg[k]  <= core_id[k*ID_WIDTH +: ID_WIDTH];
                end else if (grant_clr[k]) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

`ifdef FPROC_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles spent in ISSUE/WAIT; restarts from zero every time the FSM leaves them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE || state == WAIT) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign timed_out = (state == ISSUE || state == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    // Without the watchdog the limit has no effect; keep it referenced for lint.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timed_out          = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gnt        <= '0;
            rr_ptr     <= '0;
            fp.fp_req  <= 1'b0;
            fp.fp_id   <= '0;
            core_valid <= '0;
            core_data  <= '0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
            core_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (grant_found) begin
                        gnt       <= grant_idx;
                        rr_ptr    <= grant_next_ptr;
                        fp.fp_req <= 1'b1;
                        fp.fp_id  <= id_reg[grant_idx];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (fp.fp_ack && fp.fp_valid) begin
                        fp.fp_req  <= 1'b0;
                        core_data  <= fp.fp_data;
                        err_q      <= 1'b0;
                        core_valid <= gnt_mask;
                        state      <= RETURN;
                    end else if (fp.fp_ack) begin
                        fp.fp_req <= 1'b0;
                        state     <= WAIT;
                    end else if (timed_out) begin
                        fp.fp_req  <= 1'b0;
                        core_data  <= '0;
                        err_q      <= 1'b1;
                        core_valid <= gnt_mask;
                        state      <= RETURN;
                    end
                end
                WAIT: begin
                    if (fp.fp_valid) begin
                        core_data  <= fp.fp_data;
                        err_q      <= 1'b0;
                        core_valid <= gnt_mask;
                        state      <= RETURN;
                    end else if (timed_out) begin
                        core_data  <= '0;
                        err_q      <= 1'b1;
                        core_valid <= gnt_mask;
                        state      <= RETURN;
                    end
                end
                RETURN: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fproc_arbiter.sv
// tb_fproc_arbiter: directed stimulus with a scoreboard; expected fp_id and core results are queued
// at issue time and checked by an independent monitor whenever the DUT presents them.
module tb_fproc_arbiter;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int DW = 32;

    typedef struct {
        logic [N-1:0]  mask;
        logic [DW-1:0] data;
        logic          err;
    } res_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    core_en;
    logic [N*IW-1:0] core_id;
    logic [N-1:0]    core_valid;
    logic [DW-1:0]   core_data;
    logic            core_err;
    logic            busy;

    fproc_arbiter_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) fp_bus ();

    fproc_arbiter #(
        .N_CORES    (N),
        .ID_WIDTH   (IW),
        .DATA_WIDTH (DW),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .core_en   (core_en),
        .core_id   (core_id),
        .core_valid(core_valid),
        .core_data (core_data),
        .core_err  (core_err),
        .fp        (fp_bus),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [IW-1:0] exp_id[$];
    res_t          exp_res[$];
    res_t          r;
    logic          prev_req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        core_en         = '0;
        core_id         = '0;
        fp_bus.fp_ack   = 1'b0;
        fp_bus.fp_valid = 1'b0;
        fp_bus.fp_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    // fproc model: waits for a request, acks after ack_wait cycles, returns a result val_wait cycles later.
    task automatic serve(input int ack_wait, input int val_wait, input bit echo, input logic [DW-1:0] data);
        int            t = 0;
        logic [DW-1:0] d;
        while (fp_bus.fp_req !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check("fp_req_seen", 64'(fp_bus.fp_req), 64'd1);
        d = echo ? DW'(fp_bus.fp_id) : data;
        repeat (ack_wait) tick();
        fp_bus.fp_ack = 1'b1;
        tick();
        fp_bus.fp_ack = 1'b0;
        repeat (val_wait) tick();
        fp_bus.fp_valid = 1'b1;
        fp_bus.fp_data  = d;
        tick();
        fp_bus.fp_valid = 1'b0;
        fp_bus.fp_data  = '0;
    endtask

    // Monitor: compares every new fproc request and every core result against the queued expectations.
    always @(negedge clk) begin
        if (reset) begin
            if (fp_bus.fp_req && !prev_req) begin
                if (exp_id.size() == 0) check("unexpected_fp_req", 64'(fp_bus.fp_req), 64'd0);
                else                    check("fp_id", 64'(fp_bus.fp_id), 64'(exp_id.pop_front()));
            end
            if (core_valid != '0) begin
                if (exp_res.size() == 0) begin
                    check("unexpected_core_valid", 64'(core_valid), 64'd0);
                end else begin
                    r = exp_res.pop_front();
                    check("res_mask", 64'(core_valid), 64'(r.mask));
                    check("res_data", 64'(core_data), 64'(r.data));
                    check("res_err", 64'(core_err), 64'(r.err));
                end
            end
        end
        prev_req <= fp_bus.fp_req;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset           = 1'b0;
        core_en         = '0;
        core_id         = '0;
        fp_bus.fp_ack   = 1'b0;
        fp_bus.fp_valid = 1'b0;
        fp_bus.fp_data  = '0;
        #1;
        check("rst_core_valid", 64'(core_valid), 64'd0);
        check("rst_core_data", 64'(core_data), 64'd0);
        check("rst_core_err", 64'(core_err), 64'd0);
        check("rst_fp_req", 64'(fp_bus.fp_req), 64'd0);
        check("rst_fp_id", 64'(fp_bus.fp_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single request from core 1 with exact cycle timing.
        core_en = 4'b0010;
        core_id = {8'h00, 8'h00, 8'h2A, 8'h00};
        exp_id.push_back(8'h2A);
        exp_res.push_back('{4'b0010, 32'hDEADBEEF, 1'b0});
        tick();
        core_en = '0;
        check("t1_req_n1", 64'(fp_bus.fp_req), 64'd0);
        check("t1_busy_n1", 64'(busy), 64'd1);
        tick();
        check("t1_req_n2", 64'(fp_bus.fp_req), 64'd1);
        check("t1_id_n2", 64'(fp_bus.fp_id), 64'h2A);
        tick();
        fp_bus.fp_ack = 1'b1;
        tick();
        fp_bus.fp_ack = 1'b0;
        check("t1_req_drop", 64'(fp_bus.fp_req), 64'd0);
        tick();
        fp_bus.fp_valid = 1'b1;
        fp_bus.fp_data  = 32'hDEADBEEF;
        tick();
        fp_bus.fp_valid = 1'b0;
        fp_bus.fp_data  = '0;
        check("t1_valid_n6", 64'(core_valid), 64'b0010);
        check("t1_data_n6", 64'(core_data), 64'hDEADBEEF);
        tick();
        check("t1_pulse_end", 64'(core_valid), 64'd0);

        // Contention with rr_ptr=2: cores 0,1,3 pending -> order 3,0,1.
        core_en = 4'b1011;
        core_id = {8'hA3, 8'h00, 8'hA1, 8'hA0};
        exp_id.push_back(8'hA3);
        exp_id.push_back(8'hA0);
        exp_id.push_back(8'hA1);
        exp_res.push_back('{4'b1000, 32'h0000_00C3, 1'b0});
        exp_res.push_back('{4'b0001, 32'h0000_00C0, 1'b0});
        exp_res.push_back('{4'b0010, 32'h0000_00C1, 1'b0});
        tick();
        core_en = '0;
        serve(1, 0, 1'b0, 32'h0000_00C3);
        serve(0, 2, 1'b0, 32'h0000_00C0);
        serve(2, 1, 1'b0, 32'h0000_00C1);
        tick();
        check("rr_busy_after", 64'(busy), 64'd0);

        // Duplicate request from core 2 while pending: second id is dropped.
        core_en = 4'b0100;
        core_id = {8'h00, 8'h05, 8'h00, 8'h00};
        exp_id.push_back(8'h05);
        exp_res.push_back('{4'b0100, 32'h0000_0505, 1'b0});
        tick();
        core_id = {8'h00, 8'h07, 8'h00, 8'h00};
        tick();
        core_en = '0;
        serve(0, 1, 1'b0, 32'h0000_0505);
        repeat (4) tick();
        check("dup_busy", 64'(busy), 64'd0);
        check("dup_fp_req", 64'(fp_bus.fp_req), 64'd0);

        // Stray fp_valid in ISSUE without ack is ignored; ack+valid together returns next cycle.
        core_en = 4'b0001;
        core_id = {8'h00, 8'h00, 8'h00, 8'h44};
        exp_id.push_back(8'h44);
        exp_res.push_back('{4'b0001, 32'h0000_0001, 1'b0});
        tick();
        core_en = '0;
        tick();
        check("t4_req", 64'(fp_bus.fp_req), 64'd1);
        fp_bus.fp_valid = 1'b1;
        fp_bus.fp_data  = 32'hBADBAD00;
        tick();
        check("t4_stray_hold", 64'(fp_bus.fp_req), 64'd1);
        fp_bus.fp_ack  = 1'b1;
        fp_bus.fp_data = 32'h0000_0001;
        tick();
        fp_bus.fp_ack   = 1'b0;
        fp_bus.fp_valid = 1'b0;
        fp_bus.fp_data  = '0;
        check("t4_valid", 64'(core_valid), 64'b0001);
        check("t4_data", 64'(core_data), 64'd1);
        tick();
        check("t4_pulse_end", 64'(core_valid), 64'd0);
        fp_bus.fp_valid = 1'b1;
        fp_bus.fp_data  = 32'h0000_DEAD;
        tick();
        fp_bus.fp_valid = 1'b0;
        fp_bus.fp_data  = '0;
        repeat (2) tick();
        check("idle_valid_ignored", 64'(busy), 64'd0);
        check("core_data_held", 64'(core_data), 64'd1);

        // Full bursts after reset, fproc echoes the id: order 0,1,2,3 twice.
        do_reset();
        core_en = 4'b1111;
        core_id = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < N; k++) begin
            exp_id.push_back(IW'(8'h10 + k));
            exp_res.push_back('{N'(1) << k, DW'(8'h10 + k), 1'b0});
        end
        tick();
        core_en = '0;
        for (int k = 0; k < N; k++) serve(0, 0, 1'b1, '0);
        tick();
        core_en = 4'b1111;
        core_id = {8'h23, 8'h22, 8'h21, 8'h20};
        for (int k = 0; k < N; k++) begin
            exp_id.push_back(IW'(8'h20 + k));
            exp_res.push_back('{N'(1) << k, DW'(8'h20 + k), 1'b0});
        end
        tick();
        core_en = '0;
        for (int k = 0; k < N; k++) serve(1, 1, 1'b1, '0);
        tick();
        check("burst_busy", 64'(busy), 64'd0);

        // Reset asserted while waiting for the result.
        core_en = 4'b0010;
        core_id = {8'h00, 8'h00, 8'h55, 8'h00};
        exp_id.push_back(8'h55);
        tick();
        core_en = '0;
        tick();
        fp_bus.fp_ack = 1'b1;
        tick();
        fp_bus.fp_ack = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_fp_req", 64'(fp_bus.fp_req), 64'd0);
        check("t5_rst_fp_id", 64'(fp_bus.fp_id), 64'd0);
        check("t5_rst_core_data", 64'(core_data), 64'd0);
        check("t5_rst_core_valid", 64'(core_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        core_en = 4'b1000;
        core_id = {8'h33, 8'h00, 8'h00, 8'h00};
        exp_id.push_back(8'h33);
        exp_res.push_back('{4'b1000, 32'h3333_0000, 1'b0});
        tick();
        core_en = '0;
        serve(1, 2, 1'b0, 32'h3333_0000);
        check("t5_valid", 64'(core_valid), 64'b1000);
        tick();

`ifdef FPROC_ARB_TIMEOUT_EN
        // Watchdog: no ack ever; RETURN 16 cycles after entering ISSUE with an error result.
        core_en = 4'b0100;
        core_id = {8'h00, 8'h66, 8'h00, 8'h00};
        exp_id.push_back(8'h66);
        exp_res.push_back('{4'b0100, 32'h0, 1'b1});
        tick();
        core_en = '0;
        tick();
        check("t6_req", 64'(fp_bus.fp_req), 64'd1);
        repeat (16) tick();
        check("t6_valid", 64'(core_valid), 64'b0100);
        check("t6_err", 64'(core_err), 64'd1);
        check("t6_req_drop", 64'(fp_bus.fp_req), 64'd0);
        tick();
        check("t6_err_clear", 64'(core_err), 64'd0);
        fp_bus.fp_valid = 1'b1;
        fp_bus.fp_data  = 32'hFFFF_FFFF;
        tick();
        fp_bus.fp_valid = 1'b0;
        fp_bus.fp_data  = '0;
        repeat (2) tick();
        check("t6_late_busy", 64'(busy), 64'd0);
`endif

        repeat (4) tick();
        check("exp_id_drained", 64'(exp_id.size()), 64'd0);
        check("exp_res_drained", 64'(exp_res.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
